// File: rtl/l1c_axi_master.sv
// AXI4 master for the L1 cache: a line fill becomes a 4-beat read burst, a store becomes a single-beat write.
// Build option: define L1C_CRIT_WORD_FIRST_EN for wrapping critical-word-first line fills.
module l1c_axi_master #(
  parameter logic [3:0] ID = 4'd0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [31:0]  req_addr,
  input  logic [31:0]  req_wdata,
  input  logic [3:0]   req_wstrb,
  output logic         resp_valid,
  output logic [127:0] resp_rdata,
  output logic         resp_err,
  output logic         crit_valid,
  output logic [31:0]  crit_word,
  output logic [3:0]   ARID,
  output logic [31:0]  ARADDR,
  output logic [3:0]   ARLEN,
  output logic [2:0]   ARSIZE,
  output logic [1:0]   ARBURST,
  output logic         ARVALID,
  input  logic         ARREADY,
  input  logic [3:0]   RID,
  input  logic [31:0]  RDATA,
  input  logic [1:0]   RRESP,
  input  logic         RLAST,
  input  logic         RVALID,
  output logic         RREADY,
  output logic [3:0]   AWID,
  output logic [31:0]  AWADDR,
  output logic [3:0]   AWLEN,
  output logic [2:0]   AWSIZE,
  output logic [1:0]   AWBURST,
  output logic         AWVALID,
  input  logic         AWREADY,
  output logic [31:0]  WDATA,
  output logic [3:0]   WSTRB,
  output logic         WLAST,
  output logic         WVALID,
  input  logic         WREADY,
  input  logic [3:0]   BID,
  input  logic [1:0]   BRESP,
  input  logic         BVALID,
  output logic         BREADY
);
  localparam int unsigned BEATS  = 4;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LINE_W = WORD_W * BEATS;

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_e;

  state_e                       state_q, state_d;
  logic [31:0]                  addr_q, addr_d;
  logic [31:0]                  wdata_q, wdata_d;
  logic [3:0]                   wstrb_q, wstrb_d;
  logic                         wr_q, wr_d;
  logic [BEATS-1:0][WORD_W-1:0] line_q, line_d;
  logic [1:0]                   slot_q, slot_d;
  logic [1:0]                   beat_q, beat_d;
  logic                         err_q, err_d;
  logic                         req_ready_q, req_ready_d;
  logic                         arvalid_q, arvalid_d;
  logic                         rready_q, rready_d;
  logic                         awvalid_q, awvalid_d;
  logic                         wvalid_q, wvalid_d;
  logic                         bready_q, bready_d;
  logic                         resp_valid_q, resp_valid_d;
  logic                         resp_err_q, resp_err_d;
  logic [LINE_W-1:0]            resp_rdata_q, resp_rdata_d;
  logic [1:0]                   first_slot_c;
  logic [1:0]                   ar_burst_c;
  logic                         unused_c;

`ifdef L1C_CRIT_WORD_FIRST_EN
  // Wrapping fill starts at the requested word so it can be forwarded early.
  assign ARADDR       = {addr_q[31:2], 2'b00};
  assign ar_burst_c   = 2'b10;
  assign first_slot_c = addr_q[3:2];

  logic        crit_valid_q, crit_valid_d;
  logic [31:0] crit_word_q, crit_word_d;

  always_comb begin
    crit_valid_d = 1'b0;
    crit_word_d  = crit_word_q;
    if (state_q == RD_DATA && RVALID && beat_q == 2'd0) begin
      crit_valid_d = 1'b1;
      crit_word_d  = RDATA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crit_valid_q <= 1'b0;
      crit_word_q  <= '0;
    end else begin
      crit_valid_q <= crit_valid_d;
      crit_word_q  <= crit_word_d;
    end
  end

  assign crit_valid = crit_valid_q;
  assign crit_word  = crit_word_q;
`else
  assign ARADDR       = {addr_q[31:4], 4'h0};
  assign ar_burst_c   = 2'b01;
  assign first_slot_c = 2'b00;
  assign crit_valid   = 1'b0;
  assign crit_word    = '0;
`endif

  // Next-state, request capture, line assembly and handshake bookkeeping.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wr_d      = wr_q;
    line_d    = line_q;
    slot_d    = slot_q;
    beat_d    = beat_q;
    err_d     = err_q;
    awvalid_d = 1'b0;
    wvalid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          wr_d    = req_write;
          if (req_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            state_d = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        if (ARREADY) begin
          slot_d  = first_slot_c;
          beat_d  = 2'd0;
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (RVALID) begin
          line_d[slot_q] = RDATA;
          slot_d = slot_q + 2'd1;
          beat_d = beat_q + 2'd1;
          if (RRESP != 2'b00 || RLAST != (beat_q == 2'(BEATS - 1))) begin
            err_d = 1'b1;
          end
          if (beat_q == 2'(BEATS - 1)) begin
            state_d = DONE;
          end
        end
      end
      WR_REQ: begin
        // Each channel retires independently; leave once both have handshaken.
        awvalid_d = awvalid_q & ~AWREADY;
        wvalid_d  = wvalid_q & ~WREADY;
        if (!awvalid_d && !wvalid_d) begin
          state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (BVALID) begin
          if (BRESP != 2'b00) begin
            err_d = 1'b1;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d  = (state_d == IDLE);
    arvalid_d    = (state_d == RD_ADDR);
    rready_d     = (state_d == RD_DATA);
    bready_d     = (state_d == WR_RESP);
    resp_valid_d = (state_d == DONE);
    resp_err_d   = (state_d == DONE) & err_d;
    resp_rdata_d = (state_d == DONE && !wr_d) ? line_d : resp_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      wr_q         <= 1'b0;
      line_q       <= '0;
      slot_q       <= '0;
      beat_q       <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      wr_q         <= wr_d;
      line_q       <= line_d;
      slot_q       <= slot_d;
      beat_q       <= beat_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

  assign ARID    = ID;
  assign ARLEN   = 4'(BEATS - 1);
  assign ARSIZE  = 3'b010;
  assign ARBURST = ar_burst_c;
  assign ARVALID = arvalid_q;
  assign RREADY  = rready_q;

  assign AWID    = ID;
  assign AWADDR  = {addr_q[31:2], 2'b00};
  assign AWLEN   = 4'd0;
  assign AWSIZE  = 3'b010;
  assign AWBURST = 2'b01;
  assign AWVALID = awvalid_q;
  assign WDATA   = wdata_q;
  assign WSTRB   = wstrb_q;
  assign WLAST   = 1'b1;
  assign WVALID  = wvalid_q;
  assign BREADY  = bready_q;

  // Response IDs are not checked and the byte offset is implied by WSTRB.
  assign unused_c = ^{RID, BID, addr_q[1:0]};

endmodule
